// File: rtl/zz_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | zz_cpu_pkg : shared register map and trap FSM encoding         |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
package zz_cpu_pkg;

   localparam logic [3:0] REG_R0  = 4'b0000;
   localparam logic [3:0] REG_R1  = 4'b0001;
   localparam logic [3:0] REG_R2  = 4'b0010;
   localparam logic [3:0] REG_R3  = 4'b0011;
   localparam logic [3:0] REG_R4  = 4'b0100;
   localparam logic [3:0] REG_R5  = 4'b0101;
   localparam logic [3:0] REG_R6  = 4'b0110;
   localparam logic [3:0] REG_R7  = 4'b0111;
   localparam logic [3:0] REG_SP  = 4'b1000;
   localparam logic [3:0] REG_T   = 4'b1001;
   localparam logic [3:0] REG_IH  = 4'b1010;
   localparam logic [3:0] REG_RA  = 4'b1011;
   localparam logic [3:0] REG_EPC = 4'b1100;

   localparam int STATE_W = 1;
   localparam logic [STATE_W-1:0] ST_RUN  = 1'b0;
   localparam logic [STATE_W-1:0] ST_TRAP = 1'b1;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [3:0]  wrreg;
      logic [15:0] alu;
      logic [15:0] rdata;
      logic        memtoreg;
      logic        squash;
   } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/wb_epc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | wb_epc_ctrl : trap/ERET sequencing, EPC capture, lost-trap flag |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
module wb_epc_ctrl
   import zz_cpu_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ev_valid_i,
   input  logic        trap_i,
   input  logic        eret_i,
   input  logic [15:0] pc_i,
   output logic [15:0] epc_o,
   output logic        in_trap_o,
   output logic        trap_lost_o
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [15:0]        epc_q, epc_d;
   logic               lost_q, lost_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
         epc_q   <= 16'h0000;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         lost_q  <= lost_d;
      end
   end

   // Inside the handler a coincident ERET still exits; the trap is dropped.
   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      lost_d  = lost_q;
      if (ev_valid_i) begin
         case (state_q)
            ST_RUN: begin
               if (trap_i) begin
                  epc_d   = pc_i;
                  state_d = ST_TRAP;
               end
            end
            ST_TRAP: begin
               if (eret_i) state_d = ST_RUN;
               if (trap_i) lost_d = 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      epc_o       = epc_q;
      in_trap_o   = (state_q == ST_TRAP);
      trap_lost_o = lost_q;
   end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------+
// | wb_stage : MEM/WB register, write-back select, retire counter  |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
module wb_stage
   import zz_cpu_pkg::*;
#(
   parameter logic [3:0] EPC_ADDR = 4'b1100,
   parameter int         CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             mem_valid_i,
   input  logic             mem_regwrite_i,
   input  logic [3:0]       mem_wrreg_i,
   input  logic [15:0]      mem_alu_i,
   input  logic [15:0]      mem_rdata_i,
   input  logic             mem_memtoreg_i,
   input  logic [15:0]      mem_pc_i,
   input  logic             trap_i,
   input  logic             eret_i,
   output logic             regwrite_o,
   output logic [3:0]       wrreg_o,
   output logic [15:0]      wdata_o,
   output logic [15:0]      epc_o,
   output logic             fwd_valid_o,
   output logic [3:0]       fwd_reg_o,
   output logic [15:0]      fwd_data_o,
   output logic             in_trap_o,
   output logic             trap_lost_o,
   output logic [CNT_W-1:0] retired_o
);

   mem_wb_t          pipe_q, pipe_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             capture;
   logic             wr_en;
   logic [15:0]      wr_data;

   assign capture = !flush_i && !stall_i;

   always_ff @(posedge CLK) begin
      if (RST) begin
         pipe_q    <= '0;
         retired_q <= '0;
      end else begin
         pipe_q    <= pipe_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      pipe_d    = pipe_q;
      retired_d = retired_q;
      if (flush_i) begin
         pipe_d.valid = 1'b0;
      end else if (!stall_i) begin
         pipe_d.valid    = mem_valid_i;
         pipe_d.regwrite = mem_regwrite_i;
         pipe_d.wrreg    = mem_wrreg_i;
         pipe_d.alu      = mem_alu_i;
         pipe_d.rdata    = mem_rdata_i;
         pipe_d.memtoreg = mem_memtoreg_i;
         pipe_d.squash   = trap_i;
         if (mem_valid_i && !trap_i)
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // The EPC slot is written only through the dedicated epc_o path.
   always_comb begin
      wr_en   = pipe_q.valid && pipe_q.regwrite && !pipe_q.squash &&
                (pipe_q.wrreg != EPC_ADDR);
      wr_data = pipe_q.memtoreg ? pipe_q.rdata : pipe_q.alu;
   end

   always_comb begin
      regwrite_o  = wr_en;
      wrreg_o     = pipe_q.wrreg;
      wdata_o     = wr_data;
      fwd_valid_o = wr_en;
      fwd_reg_o   = pipe_q.wrreg;
      fwd_data_o  = wr_data;
      retired_o   = retired_q;
   end

   wb_epc_ctrl u_epc_ctrl (
      .CLK         (CLK),
      .RST         (RST),
      .ev_valid_i  (mem_valid_i && capture),
      .trap_i      (trap_i),
      .eret_i      (eret_i),
      .pc_i        (mem_pc_i),
      .epc_o       (epc_o),
      .in_trap_o   (in_trap_o),
      .trap_lost_o (trap_lost_o)
   );

endmodule
`default_nettype wire
